i2c_master_uc: RTL

- Bus-initiator control unit for the team's I2C-style link; the counterpart of the slave address/data unit.
- Takes a command (target address, direction, byte count) from local logic and generates the full bus sequence from one system clock: START, address bits, R/W bit, ack slot, data bytes with ack slots, STOP.
- Bit order and ack polarity match the slave side of the link:
  - Address and data are sent LSB first.
  - Ack = SDA sampled HIGH in the ack slot.
- SDA is modelled open-drain through out/oe/in pins; the top level instantiates the pad.

---
 rtl/i2c_master_uc_if.sv | 45 ++++
 rtl/i2c_master_uc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_uc_if.sv
// i2c_master_uc_if
//   Command, data and pad signals between the bus-initiator unit and local
//   logic / the SDA pad.
//
//   Handshakes:
//     Start/Busy   : Start is a one-cycle strobe, taken only while Busy=0. The
//                    command fields (Address, RorW, ByteCount) are sampled
//                    in that cycle. Busy stays high until the Done pulse.
//     TxReq/TxData : TxReq is a one-cycle request. Local logic must present
//                    the next write byte on TxData in that same cycle.
//     RxValid/RxData : RxValid pulses for one cycle when RxData holds a new
//                    byte. There is no back-pressure, so capture it then.
//   Pad: SDA_o is always 0. SDA_oe=1 pulls the line low, and SDA_oe=0
//   releases it. SDA_i is the already-synchronised line level.
//
//   Modports: master = the bus-initiator unit, slave = the local side.
interface i2c_master_uc_if #(
  parameter int ADDRESSLENGTH = 7
);
  logic                     Start;
  logic [ADDRESSLENGTH-1:0] Address;
  logic                     RorW;
  logic [7:0]               ByteCount;
  logic [7:0]               TxData;
  logic                     TxReq;
  logic [7:0]               RxData;
  logic                     RxValid;
  logic                     Busy;
  logic                     Done;
  logic                     Nack;
  logic                     SCL;
  logic                     SDA_o;
  logic                     SDA_oe;
  logic                     SDA_i;

  modport master (
    input  Start, Address, RorW, ByteCount, TxData, SDA_i,
    output TxReq, RxData, RxValid, Busy, Done, Nack, SCL, SDA_o, SDA_oe
  );

  modport slave (
    output Start, Address, RorW, ByteCount, TxData, SDA_i,
    input  TxReq, RxData, RxValid, Busy, Done, Nack, SCL, SDA_o, SDA_oe
  );
endinterface

// File: rtl/i2c_master_uc.sv
// i2c_master_uc
//   Bus-initiator control unit. It accepts one command (address, direction,
//   byte count) and generates the whole bus sequence: START, address bits,
//   R/W, ack slot, data bytes with ack slots, and STOP. Address and data go
//   out LSB first. An ack is SDA sampled HIGH in the ack slot.
// Ports:
//   Clk       : system clock, posedge
//   Rst_n     : asynchronous active-low reset; releases the bus at once
//   bus       : i2c_master_uc_if.master (command, data, status, SCL/SDA pad)
//   dbg_state : current FSM state, for observation only
module i2c_master_uc #(
  parameter int ADDRESSLENGTH = 7,
  parameter int CLKDIV        = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  i2c_master_uc_if.master        bus,
  output logic [3:0]             dbg_state
);
  localparam int QW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [QW-1:0] QMAX  = QW'(CLKDIV - 1);
  localparam logic [7:0]    ALAST = 8'(ADDRESSLENGTH - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_RW    = 4'd3;
  localparam logic [3:0] S_AACK  = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_WACK  = 4'd6;
  localparam logic [3:0] S_RACK  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;

  logic [3:0]               state_q, state_d;
  logic [QW-1:0]            qcnt_q, qcnt_d;
  logic [1:0]               phase_q, phase_d;
  logic [7:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [ADDRESSLENGTH-1:0] addr_sh_q, addr_sh_d, addr_next;
  logic                     rw_q, rw_d;
  logic [7:0]               tx_sh_q, tx_sh_d, tx_next;
  logic [7:0]               rx_sh_q, rx_sh_d;
  logic [7:0]               rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     tx_req_q, tx_req_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     nack_q, nack_d;
  logic                     ack_q, ack_d;
  logic                     scl_q, scl_d;
  logic                     sda_oe_q, sda_oe_d;
  logic                     tick, sample, boundary;

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    addr_sh_d  = addr_sh_q;
    rw_d       = rw_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    nack_d     = nack_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    addr_next  = addr_sh_q >> 1;
    tx_next    = tx_sh_q >> 1;
    tick       = (qcnt_q == QMAX);
    // sample: SCL rises (q1 -> q2); boundary: next bit starts (q3 -> q0)
    sample     = tick && (phase_q == 2'd1);
    boundary   = tick && (phase_q == 2'd3);

    if (state_q == S_IDLE) begin
      if (bus.Start && !busy_q) begin
        addr_sh_d = bus.Address;
        rw_d      = bus.RorW;
        cnt_d     = bus.ByteCount;
        nack_d    = 1'b0;
        busy_d    = 1'b1;
        state_d   = S_START;
        // START reuses the SCL-high half (q2,q3) of the bit timing, with SDA low
        phase_d   = 2'd2;
        qcnt_d    = '0;
        sda_oe_d  = 1'b1;
      end
    end else begin
      qcnt_d = tick ? '0 : qcnt_q + QW'(1);
      if (tick) phase_d = phase_q + 2'd1;
      // TxData is valid in the TxReq cycle and is captured at its end
      if (tx_req_q) tx_sh_d = bus.TxData;

      if (sample) begin
        case (state_q)
          S_AACK: begin
            ack_d = bus.SDA_i;
            if (!bus.SDA_i) nack_d = 1'b1;
            else if (cnt_q != 8'd0 && !rw_q) tx_req_d = 1'b1;
          end
          S_WACK: begin
            ack_d = bus.SDA_i;
            if (!bus.SDA_i) nack_d = 1'b1;
            else begin
              cnt_d = cnt_q - 8'd1;
              if (cnt_q != 8'd1) tx_req_d = 1'b1;
            end
          end
          S_DATA: begin
            if (rw_q) begin
              rx_sh_d = {bus.SDA_i, rx_sh_q[7:1]};
              if (bit_cnt_q == 8'd7) begin
                rx_data_d  = {bus.SDA_i, rx_sh_q[7:1]};
                rx_valid_d = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      // STOP: release SDA on entry to q3 so it rises while SCL is high
      if (tick && phase_q == 2'd2 && state_q == S_STOP) sda_oe_d = 1'b0;

      if (boundary) begin
        case (state_q)
          S_START: begin
            state_d   = S_ADDR;
            bit_cnt_d = 8'd0;
            sda_oe_d  = !addr_sh_q[0];
          end
          S_ADDR: begin
            if (bit_cnt_q == ALAST) begin
              state_d  = S_RW;
              sda_oe_d = !rw_q;
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd1;
              addr_sh_d = addr_next;
              sda_oe_d  = !addr_next[0];
            end
          end
          S_RW: begin
            state_d  = S_AACK;
            sda_oe_d = 1'b0;
          end
          S_AACK, S_WACK: begin
            // WACK has already decremented the count at its sample point
            if (!ack_q || cnt_q == 8'd0) begin
              state_d  = S_STOP;
              sda_oe_d = 1'b1;
            end else begin
              state_d   = S_DATA;
              bit_cnt_d = 8'd0;
              sda_oe_d  = rw_q ? 1'b0 : !tx_sh_q[0];
            end
          end
          S_DATA: begin
            if (bit_cnt_q == 8'd7) begin
              if (rw_q) begin
                state_d  = S_RACK;
                cnt_d    = cnt_q - 8'd1;
                // master ack: released (high) to continue, pulled low on last byte
                sda_oe_d = (cnt_q == 8'd1);
              end else begin
                state_d  = S_WACK;
                sda_oe_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd1;
              if (rw_q) sda_oe_d = 1'b0;
              else begin
                tx_sh_d  = tx_next;
                sda_oe_d = !tx_next[0];
              end
            end
          end
          S_RACK: begin
            if (cnt_q == 8'd0) begin
              state_d  = S_STOP;
              sda_oe_d = 1'b1;
            end else begin
              state_d   = S_DATA;
              bit_cnt_d = 8'd0;
              sda_oe_d  = 1'b0;
            end
          end
          S_STOP: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            sda_oe_d = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    scl_d = (state_d == S_IDLE) ? 1'b1 : phase_d[1];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      phase_q    <= 2'd0;
      bit_cnt_q  <= 8'd0;
      cnt_q      <= 8'd0;
      addr_sh_q  <= '0;
      rw_q       <= 1'b0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
      ack_q      <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      addr_sh_q  <= addr_sh_d;
      rw_q       <= rw_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
      ack_q      <= ack_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign bus.TxReq   = tx_req_q;
  assign bus.RxData  = rx_data_q;
  assign bus.RxValid = rx_valid_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Nack    = nack_q;
  assign bus.SCL     = scl_q;
  assign bus.SDA_o   = 1'b0;
  assign bus.SDA_oe  = sda_oe_q;
  assign dbg_state   = state_q;
endmodule
